// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared state encodings, word width and limits for the data memory responder.
// Optional feature macro used by the top: DATA_MEM_RESP_STATS_EN.
package data_mem_responder_pkg;
    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        ACCESS_WAIT = 2'b01,
        RESP        = 2'b10
    } state_t;
    localparam int WORD_W = 16;
    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam logic [WORD_W-1:0] SAT_MAX = 16'hFFFF;
endpackage

// File: rtl/data_mem_responder_array.sv
// data_mem_array: single-port synchronous RAM, 2^ADDR_W x 16, write enable, registered read.
// Ports: clk; en (access strobe); we (write when en); addr; wdata; rdata (read register, updated only on en).
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    // The read register only moves on an access, so a response holds its data while stalled.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder with programmable wait states and a valid/ready response.
// Ports: clk, reset (async, active high); req_valid/req_we/req_addr/req_wdata/req_ready request side;
// rsp_valid/rsp_ready/rsp_rdata/rsp_err response side; busy (not IDLE).
// With DATA_MEM_RESP_STATS_EN defined: stat_loads, stat_stores, stat_errors saturating counters.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
`ifdef DATA_MEM_RESP_STATS_EN
    output logic [WORD_W-1:0] stat_loads,
    output logic [WORD_W-1:0] stat_stores,
    output logic [WORD_W-1:0] stat_errors,
`endif
    output logic              busy
);
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] ram_rdata;
    logic              in_range, access, done;

    assign in_range = (addr_q >> ADDR_W) == '0;
    assign access   = state_q == ACCESS_WAIT && cnt_q == 4'd0;
    assign done     = state_q == RESP && rsp_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = ACCESS_WAIT;
            end
            ACCESS_WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                         else state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    data_mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .en    (access && in_range),
        .we    (we_q),
        .addr  (addr_q[ADDR_W-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Response fields derive from the held request, so they stay stable through a stall.
    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_err   = rsp_valid && !in_range;
    assign rsp_rdata = (rsp_valid && in_range && !we_q) ? ram_rdata : '0;

`ifdef DATA_MEM_RESP_STATS_EN
    logic [WORD_W-1:0] loads_q, loads_d, stores_q, stores_d, errors_q, errors_d;

    always_comb begin
        loads_d  = (done && in_range && !we_q && loads_q != SAT_MAX) ? loads_q + 1'b1 : loads_q;
        stores_d = (done && in_range && we_q && stores_q != SAT_MAX) ? stores_q + 1'b1 : stores_q;
        errors_d = (done && !in_range && errors_q != SAT_MAX) ? errors_q + 1'b1 : errors_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loads_q  <= '0;
            stores_q <= '0;
            errors_q <= '0;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
            errors_q <= errors_d;
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errors = errors_q;
`else
    logic unused_done;
    assign unused_done = done;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector bench for data_mem_responder (WAIT_CYCLES 2 and 0 instances).
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;

    logic        req_valid0 = 0, rsp_ready0 = 0;
    logic        req_ready0, rsp_valid0, rsp_err0, busy0;
    logic [15:0] rsp_rdata0;

`ifdef DATA_MEM_RESP_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errors, sl0, ss0, se0;
`endif

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
`ifdef DATA_MEM_RESP_STATS_EN
        .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors),
`endif
        .busy(busy)
    );

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_we(1'b1),
        .req_addr(16'h0003), .req_wdata(16'h00AA), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0),
`ifdef DATA_MEM_RESP_STATS_EN
        .stat_loads(sl0), .stat_stores(ss0), .stat_errors(se0),
`endif
        .busy(busy0)
    );

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    // One full transaction with rsp_ready low until rsp_valid shows; lat counts edges after the accept.
    task automatic txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = 0;
        @(posedge clk);
        #1 req_valid = 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    vec_t        vecs[12];
    logic [15:0] rd;
    logic        er;
    int          lat;

    initial begin
        vecs[0]  = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
        vecs[4]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
        vecs[6]  = '{1'b1, 16'h8000, 16'h1111, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
        vecs[8]  = '{1'b1, 16'h00FF, 16'h7777, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 16'h00FF, 16'h0000, 16'h7777, 1'b0};
        vecs[10] = '{1'b1, 16'h0007, 16'h5555, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 16'h0007, 16'h0000, 16'h5555, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 1);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("reset_rsp_rdata", {16'd0, rsp_rdata}, 0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 0);
        reset = 0;

        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].rdata});
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].err});
            chk($sformatf("vec%0d_latency", i), lat, 3);
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i), {30'd0, rsp_valid, req_ready}, 1);
        end

        // Stall: response held with rsp_ready low while a new request waits.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 16'h0005; rsp_ready = 0;
        @(posedge clk);
        #1 req_we = 1; req_addr = 16'h0000; req_wdata = 16'hDEAD;
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 1);
            chk("stall_rsp_rdata", {16'd0, rsp_rdata}, 32'h0000BEEF);
            chk("stall_req_ready", {31'd0, req_ready}, 0);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("stall_release_valid", {31'd0, rsp_valid}, 0);
        chk("stall_release_ready", {31'd0, req_ready}, 1);
        chk("stall_release_busy", {31'd0, busy}, 0);
        req_valid = 0; rsp_ready = 0;
        txn(1'b0, 16'h0000, 16'h0000, rd, er, lat);
        chk("stall_no_stray_store", {16'd0, rd}, 32'h0000A5A5);

        // Reset during ACCESS_WAIT of a store aborts it.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 16'h0007; req_wdata = 16'h1234;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 1);
        reset = 1;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_req_ready", {31'd0, req_ready}, 1);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("abort_rsp_rdata", {16'd0, rsp_rdata}, 0);
        chk("abort_rsp_err", {31'd0, rsp_err}, 0);
        repeat (3) @(negedge clk);
        reset = 0;
        txn(1'b0, 16'h0007, 16'h0000, rd, er, lat);
        chk("abort_no_write", {16'd0, rd}, 32'h00005555);

        // WAIT_CYCLES = 0 back-to-back: accept every third cycle.
        @(negedge clk);
        req_valid0 = 1; rsp_ready0 = 1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("b2b_ready_%0d", k), {31'd0, req_ready0}, (k % 3 == 0) ? 1 : 0);
            chk($sformatf("b2b_valid_%0d", k), {31'd0, rsp_valid0}, (k % 3 == 2) ? 1 : 0);
            @(negedge clk);
        end
        req_valid0 = 0;

`ifdef DATA_MEM_RESP_STATS_EN
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("stat_reset_loads", {16'd0, stat_loads}, 0);
        txn(1'b0, 16'h0005, 16'h0000, rd, er, lat);
        txn(1'b1, 16'h0010, 16'h0101, rd, er, lat);
        txn(1'b0, 16'h0010, 16'h0000, rd, er, lat);
        txn(1'b0, 16'h0200, 16'h0000, rd, er, lat);
        txn(1'b1, 16'h0011, 16'h0202, rd, er, lat);
        txn(1'b0, 16'h0011, 16'h0000, rd, er, lat);
        @(negedge clk);
        chk("stat_loads", {16'd0, stat_loads}, 3);
        chk("stat_stores", {16'd0, stat_stores}, 2);
        chk("stat_errors", {16'd0, stat_errors}, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
